flit_ejector: RTL and testbench

- Ejection-side network interface. Sits on a router's local output port (port 0) and consumes the head/body/tail flit stream that the router delivers.
- Checks packet framing, reassembles each packet into one wide word, and hands it to the local core over a valid/ready handshake.
- It is the receiving end of the flit-injection protocol used at router local inputs.

---
 rtl/flit_ejector.sv | 110 +++++++++++
 tb/tb_flit_ejector.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_ejector.sv
// Ejection-side network interface: checks head/body/tail framing on the router's
// local output, reassembles each packet into one wide word and hands it to the core.
module flit_ejector #(
    parameter int N             = 2,
    parameter int INDEX         = 0,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int ERR_W         = 8
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DATA_WIDTH-1:0]                               flit_in,
    input  logic                                                flit_valid,
    output logic                                                flit_ready,
    output logic [FlitPerPacket*(DATA_WIDTH-TYPE_WIDTH)-1:0]    pkt_data,
    output logic                                                pkt_valid,
    input  logic                                                pkt_ready,
    output logic                                                pkt_misrouted,
    output logic                                                err_pulse,
    output logic [ERR_W-1:0]                                    err_count
);
    localparam int PW     = DATA_WIDTH - TYPE_WIDTH;
    localparam int DEST_W = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(FlitPerPacket);

    localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] T_BODY = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);

    typedef enum logic [1:0] {IDLE, BODY, TAIL, HOLD} state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt, cnt_inc;
    logic [FlitPerPacket-1:0][PW-1:0] words;
    logic                         wr_en, mis_ld, err, mis, rdy_en, accept;
    logic [CNT_W-1:0]             wr_idx;
    logic [TYPE_WIDTH-1:0]        ftype;

    assign ftype   = flit_in[DATA_WIDTH-1 -: TYPE_WIDTH];
    // rdy_en keeps flit_ready low until the first edge after reset release
    assign flit_ready    = rdy_en && (state != HOLD);
    assign accept        = flit_valid && flit_ready;
    assign cnt_inc       = cnt + 1'b1;
    assign pkt_valid     = (state == HOLD);
    assign pkt_data      = words;
    assign pkt_misrouted = mis;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err       = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        mis_ld    = 1'b0;
        if (state == HOLD) begin
            if (pkt_ready) state_nxt = IDLE;
        end else if (accept) begin
            if (ftype == T_HEAD) begin
                // a head always (re)starts a packet; mid-packet it is also an error
                err       = (state != IDLE);
                wr_en     = 1'b1;
                mis_ld    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = BODY;
            end else if (ftype == T_BODY) begin
                if (state == BODY) begin
                    wr_en   = 1'b1;
                    wr_idx  = cnt_inc;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_W'(FlitPerPacket - 2)) state_nxt = TAIL;
                end else begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end else if (ftype == T_TAIL) begin
                if (state == TAIL) begin
                    wr_en     = 1'b1;
                    wr_idx    = CNT_W'(FlitPerPacket - 1);
                    state_nxt = HOLD;
                end else begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_en    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            mis       <= 1'b0;
            words     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rdy_en    <= 1'b1;
            err_pulse <= err;
            if (err && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
            if (mis_ld) mis <= (flit_in[DEST_W-1:0] != DEST_W'(INDEX));
            if (wr_en) words[wr_idx] <= flit_in[PW-1:0];
        end
    end
endmodule

// File: tb/tb_flit_ejector.sv
// Directed bench for flit_ejector (INDEX=1, 6 flits/packet, 30-bit payload words).
module tb_flit_ejector;
    localparam int DW  = 32;
    localparam int TW  = 2;
    localparam int FPP = 6;
    localparam int PW  = DW - TW;
    localparam int EW  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW-1:0]     flit_in = '0;
    logic              flit_valid = 1'b0;
    logic              flit_ready;
    logic [FPP*PW-1:0] pkt_data;
    logic              pkt_valid;
    logic              pkt_ready = 1'b0;
    logic              pkt_misrouted;
    logic              err_pulse;
    logic [EW-1:0]     err_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flit_ejector #(.N(2), .INDEX(1), .DATA_WIDTH(DW), .TYPE_WIDTH(TW),
                   .FlitPerPacket(FPP), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_misrouted(pkt_misrouted),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    // expected packet: word k = w0 + k, head in the LSBs
    function automatic logic [FPP*PW-1:0] pkt_of(input logic [PW-1:0] w0);
        logic [FPP*PW-1:0] v;
        v = '0;
        for (int k = 0; k < FPP; k++) v[k*PW +: PW] = w0 + PW'(k);
        return v;
    endfunction

    task automatic do_reset();
        flit_valid = 1'b0;
        pkt_ready  = 1'b1;
        rst        = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // present a flit and return at the negedge after the edge that accepts it
    task automatic send(input logic [DW-1:0] d);
        int n;
        flit_in    = d;
        flit_valid = 1'b1;
        n = 0;
        while (!flit_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!flit_ready) begin
            errors++;
            $display("FAIL send_timeout flit=%h flit_ready=%b required 1", d, flit_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [PW-1:0] w0);
        send({2'b01, w0});
        for (int k = 1; k < FPP - 1; k++) send({2'b10, w0 + PW'(k)});
        send({2'b11, w0 + PW'(FPP - 1)});
        flit_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (flit_ready !== 1'b0 || pkt_valid !== 1'b0 || err_pulse !== 1'b0 ||
            err_count !== 8'd0 || pkt_data !== '0 || pkt_misrouted !== 1'b0) begin
            errors++;
            $display("FAIL reset_values rdy=%b pv=%b ep=%b ec=%0d mis=%b required all 0",
                     flit_ready, pkt_valid, err_pulse, err_count, pkt_misrouted);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (flit_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b required 0", flit_ready);
        end
        @(negedge clk);
        checks++;
        if (flit_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got %b required 1", flit_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_pkt(30'h1);
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h1) || pkt_misrouted !== 1'b0 ||
            flit_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_deliver pv=%b data=%h mis=%b rdy=%b required 1 %h 0 0",
                     pkt_valid, pkt_data, pkt_misrouted, flit_ready, pkt_of(30'h1));
        end
        @(negedge clk);
        checks++;
        if (pkt_valid !== 1'b0 || flit_ready !== 1'b1 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL basic_after pv=%b rdy=%b ec=%0d required 0 1 0",
                     pkt_valid, flit_ready, err_count);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        pkt_ready = 1'b0;
        send_pkt(30'h1);
        flit_in    = 32'h4000_0031;
        flit_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h1) || flit_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable bad_cycles=%0d required 0", bad);
        end
        pkt_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pkt_valid !== 1'b0 || flit_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release pv=%b rdy=%b required 0 1", pkt_valid, flit_ready);
        end
        @(negedge clk);
        for (int k = 1; k < FPP - 1; k++) send({2'b10, 30'h31 + 30'(k)});
        send(32'hC000_0036);
        flit_valid = 1'b0;
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h31) || err_count !== 8'd0) begin
            errors++;
            $display("FAIL pending_head_pkt pv=%b data=%h ec=%0d required 1 %h 0",
                     pkt_valid, pkt_data, err_count, pkt_of(30'h31));
        end
    endtask

    task automatic test_stray_body();
        do_reset();
        send(32'h8000_0007);
        flit_valid = 1'b0;
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || flit_ready !== 1'b1 || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_body_err ep=%b ec=%0d rdy=%b pv=%b required 1 1 1 0",
                     err_pulse, err_count, flit_ready, pkt_valid);
        end
        @(negedge clk);
        checks++;
        if (err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width got %b required 0", err_pulse);
        end
        send_pkt(30'h41);
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h41) || err_count !== 8'd1) begin
            errors++;
            $display("FAIL stray_body_next pv=%b data=%h ec=%0d required 1 %h 1",
                     pkt_valid, pkt_data, err_count, pkt_of(30'h41));
        end
    endtask

    task automatic test_early_tail();
        do_reset();
        send(32'h4000_0001);
        send(32'h8000_0002);
        send(32'h8000_0003);
        send(32'hC000_0009);
        flit_valid = 1'b0;
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || pkt_valid !== 1'b0 || flit_ready !== 1'b1) begin
            errors++;
            $display("FAIL early_tail_err ep=%b ec=%0d pv=%b rdy=%b required 1 1 0 1",
                     err_pulse, err_count, pkt_valid, flit_ready);
        end
        send_pkt(30'h21);
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h21) || err_count !== 8'd1) begin
            errors++;
            $display("FAIL early_tail_next pv=%b data=%h ec=%0d required 1 %h 1",
                     pkt_valid, pkt_data, err_count, pkt_of(30'h21));
        end
    endtask

    task automatic test_restart();
        do_reset();
        send(32'h4000_0001);
        send(32'h8000_0002);
        send(32'h4000_0011);
        checks++;
        if (err_pulse !== 1'b1 || pkt_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_err ep=%b pv=%b required 1 0", err_pulse, pkt_valid);
        end
        for (int k = 1; k < FPP - 1; k++) send({2'b10, 30'h11 + 30'(k)});
        send(32'hC000_0016);
        flit_valid = 1'b0;
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h11) || err_count !== 8'd1 ||
            pkt_misrouted !== 1'b0) begin
            errors++;
            $display("FAIL restart_pkt pv=%b data=%h ec=%0d mis=%b required 1 %h 1 0",
                     pkt_valid, pkt_data, err_count, pkt_misrouted, pkt_of(30'h11));
        end
    endtask

    task automatic test_type0();
        do_reset();
        send(32'h4000_0051);
        send(32'h8000_0052);
        send(32'h0000_0000);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL type0_err ep=%b ec=%0d required 1 1", err_pulse, err_count);
        end
        send(32'h8000_0053);
        send(32'h8000_0054);
        send(32'h8000_0055);
        send(32'hC000_0056);
        flit_valid = 1'b0;
        checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== pkt_of(30'h51) || err_count !== 8'd1) begin
            errors++;
            $display("FAIL type0_pkt pv=%b data=%h ec=%0d required 1 %h 1",
                     pkt_valid, pkt_data, err_count, pkt_of(30'h51));
        end
    endtask

    task automatic test_misroute_reset();
        int bad;
        do_reset();
        send_pkt(30'h20);
        checks++;
        if (pkt_valid !== 1'b1 || pkt_misrouted !== 1'b1 || pkt_data !== pkt_of(30'h20) ||
            err_count !== 8'd0) begin
            errors++;
            $display("FAIL misroute_pkt pv=%b mis=%b ec=%0d required 1 1 0",
                     pkt_valid, pkt_misrouted, err_count);
        end
        @(negedge clk);
        send(32'h8000_0000);
        send(32'h4000_0061);
        send(32'h8000_0062);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pkt_valid !== 1'b0 || flit_ready !== 1'b0 || err_count !== 8'd0 ||
            err_pulse !== 1'b0 || pkt_data !== '0 || pkt_misrouted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pv=%b rdy=%b ec=%0d ep=%b mis=%b required 0 0 0 0 0",
                     pkt_valid, flit_ready, err_count, err_pulse, pkt_misrouted);
        end
        flit_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pkt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_pkt_after_reset cycles=%0d required 0", bad);
        end
        send(32'h8000_0063);
        flit_valid = 1'b0;
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL idle_after_reset ep=%b ec=%0d required 1 1", err_pulse, err_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        flit_in    = 32'h0000_0000;
        flit_valid = 1'b1;
        repeat (254) @(negedge clk);
        checks++;
        if (err_count !== 8'd254) begin
            errors++;
            $display("FAIL err_count_254 got %0d required 254", err_count);
        end
        repeat (6) @(negedge clk);
        flit_valid = 1'b0;
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL err_count_sat got %0d required 255", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stray_body();
        test_early_tail();
        test_restart();
        test_type0();
        test_misroute_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t required finish earlier", $time);
        $fatal(1);
    end
endmodule
